// File: rtl/poly_horner_eval.sv
// Horner-rule polynomial evaluator: coefficients (highest first) and x are
// entered one per go press, then a shared multiply/add ALU iterates D times.
//
// state         | meaning
// S_LOAD        | waiting for go to load coef[idx]
// S_LOAD_WAIT   | coefficient captured, waiting for go release
// S_LOAD_X      | waiting for go to load x
// S_LOAD_X_WAIT | x captured, waiting for go release to start compute
// S_MUL         | acc <= acc * x
// S_ADD         | acc <= acc + coef[idx], finish when idx reaches 0
module poly_horner_eval #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic             expect_x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_result,
  output logic             overflow
);

  localparam logic [2:0] S_LOAD        = 3'd0;
  localparam logic [2:0] S_LOAD_WAIT   = 3'd1;
  localparam logic [2:0] S_LOAD_X      = 3'd2;
  localparam logic [2:0] S_LOAD_X_WAIT = 3'd3;
  localparam logic [2:0] S_MUL         = 3'd4;
  localparam logic [2:0] S_ADD         = 3'd5;

  localparam logic [3:0] IDX_TOP  = 4'(DEGREE);
  localparam logic [3:0] IDX_NEXT = 4'(DEGREE - 1);

  logic [2:0]         state;
  logic [3:0]         idx;
  // sized to the full 4-bit index space so idx never selects out of range
  logic [WIDTH-1:0]   coef [16];
  logic [WIDTH-1:0]   x_reg;
  logic [WIDTH-1:0]   acc;
  logic               ovf_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;

  assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_reg};
  assign sum  = {1'b0, acc} + {1'b0, coef[idx]};

  assign expect_x = (state == S_LOAD_X) || (state == S_LOAD_X_WAIT);
  assign busy     = (state == S_MUL) || (state == S_ADD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      idx         <= IDX_TOP;
      for (int i = 0; i < 16; i++) coef[i] <= '0;
      x_reg       <= '0;
      acc         <= '0;
      ovf_acc     <= 1'b0;
      data_result <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          if (go) begin
            coef[idx] <= data_in;
            state     <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          if (!go) begin
            if (idx == 4'd0) begin
              state <= S_LOAD_X;
            end else begin
              idx   <= idx - 4'd1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD_X: begin
          if (go) begin
            x_reg <= data_in;
            state <= S_LOAD_X_WAIT;
          end
        end
        S_LOAD_X_WAIT: begin
          if (!go) begin
            acc     <= coef[IDX_TOP];
            idx     <= IDX_NEXT;
            ovf_acc <= 1'b0;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          acc     <= prod[WIDTH-1:0];
          ovf_acc <= ovf_acc | (prod[2*WIDTH-1:WIDTH] != '0);
          state   <= S_ADD;
        end
        S_ADD: begin
          acc     <= sum[WIDTH-1:0];
          ovf_acc <= ovf_acc | sum[WIDTH];
          if (idx == 4'd0) begin
            data_result <= sum[WIDTH-1:0];
            overflow    <= ovf_acc | sum[WIDTH];
            done        <= 1'b1;
            idx         <= IDX_TOP;
            state       <= S_LOAD;
          end else begin
            idx   <= idx - 4'd1;
            state <= S_MUL;
          end
        end
        default: begin
          state <= S_LOAD;
          idx   <= IDX_TOP;
        end
      endcase
    end
  end

endmodule
